// File: rtl/vga_capture_monitor.sv
// vga_capture_monitor: VGA sync timing checker and visible-pixel capture.
// Define FRAME_CRC_EN to add a per-frame CRC-16-CCITT of captured pixels.
module vga_capture_monitor #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int CLKS_PER_PIX = 4,
  parameter int SYNC_ACT_LOW = 1,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  input  logic        err_clr_i,
  output logic [15:0] row_o,
  output logic [15:0] column_o,
  output logic [15:0] rgb_o,
  output logic        pixel_valid_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic        herr_o,
  output logic        verr_o
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0] frame_crc_o,
  output logic        crc_valid_o
`endif
);

  localparam logic [15:0] H_SW  = 16'(H_SYNC * CLKS_PER_PIX);
  localparam logic [15:0] H_PER =
    16'((H_VISIBLE + H_FRONT + H_SYNC + H_BACK) * CLKS_PER_PIX);
  localparam logic [15:0] H_V0  = 16'((H_SYNC + H_BACK) * CLKS_PER_PIX);
  localparam logic [15:0] H_V1  =
    16'((H_SYNC + H_BACK + H_VISIBLE) * CLKS_PER_PIX);
  localparam logic [15:0] V_SW  = 16'(V_SYNC);
  localparam logic [15:0] V_PER =
    16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [15:0] V_V0  = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_V1  = 16'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [15:0] CPP   = 16'(CLKS_PER_PIX);
  localparam logic [15:0] SMP   = 16'(CLKS_PER_PIX / 2);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);
  localparam logic        POL   = (SYNC_ACT_LOW != 0);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state;
  logic [7:0]  clean;
  logic        dirty;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [3:0]  red_q, green_q, blue_q;
  logic [15:0] h_cnt, v_cnt;
  logic        hs_lead, hs_trail, vs_lead, vs_trail;
  logic [15:0] h_inc, h_cur, v_inc, v_adv, v_cur, h_off;
  logic        h_bad, v_bad, mis, h_vis, v_vis, smp;

  // register inputs once, syncs normalised to active-high
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hs_q    <= 1'b0;
      hs_d    <= 1'b0;
      vs_q    <= 1'b0;
      vs_d    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hs_q    <= hsync_i ^ POL;
      hs_d    <= hs_q;
      vs_q    <= vsync_i ^ POL;
      vs_d    <= vs_q;
      red_q   <= red_i;
      green_q <= green_i;
      blue_q  <= blue_i;
    end
  end

  assign hs_lead  = hs_q & ~hs_d;
  assign hs_trail = ~hs_q & hs_d;
  assign vs_lead  = vs_q & ~vs_d;
  assign vs_trail = ~vs_q & vs_d;

  // h_cur / v_cur are the clock and line position of this cycle
  assign h_inc = (h_cnt == 16'hFFFF) ? h_cnt : h_cnt + 16'd1;
  assign h_cur = hs_lead ? 16'd0 : h_inc;
  assign v_inc = (v_cnt == 16'hFFFF) ? v_cnt : v_cnt + 16'd1;
  assign v_adv = hs_lead ? v_inc : v_cnt;
  assign v_cur = vs_lead ? 16'd0 : v_adv;

  assign h_bad = (hs_lead & (h_inc != H_PER)) |
                 (hs_trail & (h_cur != H_SW));
  assign v_bad = (vs_lead & (v_adv != V_PER)) |
                 (vs_trail & (v_cur != V_SW));
  assign mis   = h_bad | v_bad;

  assign h_off = h_cur - H_V0;
  assign h_vis = (h_cur >= H_V0) & (h_cur < H_V1);
  assign v_vis = (v_cur >= V_V0) & (v_cur < V_V1);
  assign smp   = h_vis & v_vis & ((h_off % CPP) == SMP);

  assign locked_o = (state == LOCKED);

  // position counters, frame pulse and sticky error flags
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      frame_start_o <= 1'b0;
      herr_o        <= 1'b0;
      verr_o        <= 1'b0;
    end else begin
      h_cnt         <= h_cur;
      v_cnt         <= v_cur;
      frame_start_o <= vs_lead;
      if (h_bad && state != SEARCH) herr_o <= 1'b1;
      else if (err_clr_i)           herr_o <= 1'b0;
      if (v_bad && state != SEARCH) verr_o <= 1'b1;
      else if (err_clr_i)           verr_o <= 1'b0;
    end
  end

  // lock acquisition: count consecutive frames free of mismatches
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= SEARCH;
      clean <= '0;
      dirty <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vs_lead) begin
            state <= ALIGN;
            clean <= '0;
            dirty <= 1'b0;
          end
        end
        ALIGN: begin
          if (mis) begin
            clean <= '0;
            dirty <= ~vs_lead;
          end else if (vs_lead) begin
            if (dirty) begin
              dirty <= 1'b0;
            end else if (clean + 8'd1 >= LOCK_N) begin
              state <= LOCKED;
              clean <= '0;
            end else begin
              clean <= clean + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (mis) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // capture one RGB565 pixel at mid-pixel while locked
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pixel_valid_o <= 1'b0;
      row_o         <= '0;
      column_o      <= '0;
      rgb_o         <= '0;
    end else begin
      pixel_valid_o <= 1'b0;
      if (smp && state == LOCKED && !mis) begin
        pixel_valid_o <= 1'b1;
        row_o         <= v_cur - V_V0;
        column_o      <= h_off / CPP;
        rgb_o         <= {red_q, red_q[3], green_q, green_q[3:2],
                          blue_q, blue_q[3]};
      end
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16(input logic [15:0] c,
                                        input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // accumulate over captured beats, publish at first line past visible
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      crc         <= 16'hFFFF;
      frame_crc_o <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      if (frame_start_o)      crc <= 16'hFFFF;
      else if (pixel_valid_o) crc <= crc16(crc, rgb_o);
      crc_valid_o <= hs_lead & (v_cur == V_V1);
      if (hs_lead && v_cur == V_V1) frame_crc_o <= crc;
    end
  end
`endif

endmodule
